stack_ctrl: RTL and testbench

Sequencer that turns push/pop/load/init commands into control strobes for one 16-bit `register` instance used as a stack pointer (SP), plus a single-beat memory handshake. Stack grows downward in 2-byte steps: push pre-decrements SP then writes; pop reads at SP then post-increments. Sits between the instruction decoder (command side) and the SP register and data-memory port. It tracks stack depth and flags overflow and underflow.

---
 rtl/stack_ctrl_if.sv | 33 +++
 rtl/stack_ctrl.sv | 101 ++++++++++
 tb/tb_stack_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: command, SP-register, memory and status signals of the stack sequencer.
interface stack_ctrl_if #(parameter int DEPTH_W = 8);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [15:0]        cmd_data;
  logic [15:0]        sp;
  logic [15:0]        sp_din;
  logic               sp_ld_en;
  logic               sp_inc_dec_en;
  logic               sp_inc_decn;
  logic [15:0]        mem_addr;
  logic [15:0]        mem_wdata;
  logic               mem_wr;
  logic               mem_rd;
  logic               mem_ack;
  logic [15:0]        mem_rdata;
  logic [15:0]        pop_data;
  logic               pop_valid;
  logic [DEPTH_W-1:0] depth;
  logic               err_ovf;
  logic               err_unf;
  modport master (
    input  cmd_valid, cmd_op, cmd_data, sp, mem_ack, mem_rdata,
    output cmd_ready, sp_din, sp_ld_en, sp_inc_dec_en, sp_inc_decn,
           mem_addr, mem_wdata, mem_wr, mem_rd, pop_data, pop_valid, depth, err_ovf, err_unf
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_data, sp, mem_ack, mem_rdata,
    input  cmd_ready, sp_din, sp_ld_en, sp_inc_dec_en, sp_inc_decn,
           mem_addr, mem_wdata, mem_wr, mem_rd, pop_data, pop_valid, depth, err_ovf, err_unf
  );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences push/pop/load/init into SP-register strobes and single-beat memory accesses.
module stack_ctrl #(
  parameter logic [15:0] STACK_TOP = 16'h0000,
  parameter int          MAX_DEPTH = 64,
  parameter int          DEPTH_W   = 8
) (
  input logic          clk,
  input logic          rst_n,
  stack_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, DEC, WR, RD, INC, LD} state_t;
  state_t state_q, state_d;
  logic [15:0] data_q;
  logic [15:0] sp_din_q, sp_din_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, pop_data_q, pop_data_d;
  logic sp_ld_en_q, sp_ld_en_d, sp_inc_dec_en_q, sp_inc_dec_en_d, sp_inc_decn_q, sp_inc_decn_d;
  logic mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d, pop_valid_q, pop_valid_d;
  logic err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic accept, full, empty, wr_done, rd_done;
  assign accept  = bus.cmd_valid && state_q == IDLE;
  assign full    = depth_q == DEPTH_W'(MAX_DEPTH);
  assign empty   = depth_q == '0;
  assign wr_done = state_q == WR && bus.mem_ack;
  assign rd_done = state_q == RD && bus.mem_ack;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bus.cmd_op[1] ? LD : bus.cmd_op[0] ? (empty ? IDLE : RD) : (full ? IDLE : DEC);
      DEC:     state_d = WR;
      WR:      state_d = bus.mem_ack ? IDLE : WR;
      RD:      state_d = bus.mem_ack ? INC : RD;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered, so each is decoded from the state being entered.
  // The register decrements on the same edge WR is entered, so the address is pre-computed here.
  always_comb begin
    sp_ld_en_d      = state_d != LD;
    sp_inc_dec_en_d = state_d != DEC && state_d != INC;
    sp_inc_decn_d   = state_d != DEC;
    sp_din_d        = accept && bus.cmd_op[1] ? (bus.cmd_op[0] ? STACK_TOP : bus.cmd_data) : sp_din_q;
    mem_wr_d        = state_d == WR;
    mem_rd_d        = state_d == RD;
    mem_addr_d      = state_q == DEC ? bus.sp - 16'd2 : accept && state_d == RD ? bus.sp : mem_addr_q;
    mem_wdata_d     = state_q == DEC ? data_q : mem_wdata_q;
    pop_data_d      = rd_done ? bus.mem_rdata : pop_data_q;
    pop_valid_d     = state_d == INC;
    depth_d         = state_d == LD ? '0 : wr_done ? depth_q + DEPTH_W'(1) : rd_done ? depth_q - DEPTH_W'(1) : depth_q;
    err_ovf_d       = state_d != LD && (err_ovf_q || (accept && bus.cmd_op == 2'b00 && full));
    err_unf_d       = state_d != LD && (err_unf_q || (accept && bus.cmd_op == 2'b01 && empty));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      data_q          <= '0;
      sp_din_q        <= '0;
      sp_ld_en_q      <= 1'b1;
      sp_inc_dec_en_q <= 1'b1;
      sp_inc_decn_q   <= 1'b1;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wr_q        <= 1'b0;
      mem_rd_q        <= 1'b0;
      pop_data_q      <= '0;
      pop_valid_q     <= 1'b0;
      depth_q         <= '0;
      err_ovf_q       <= 1'b0;
      err_unf_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      data_q          <= accept ? bus.cmd_data : data_q;
      sp_din_q        <= sp_din_d;
      sp_ld_en_q      <= sp_ld_en_d;
      sp_inc_dec_en_q <= sp_inc_dec_en_d;
      sp_inc_decn_q   <= sp_inc_decn_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wr_q        <= mem_wr_d;
      mem_rd_q        <= mem_rd_d;
      pop_data_q      <= pop_data_d;
      pop_valid_q     <= pop_valid_d;
      depth_q         <= depth_d;
      err_ovf_q       <= err_ovf_d;
      err_unf_q       <= err_unf_d;
    end
  end
  assign bus.cmd_ready     = state_q == IDLE;
  assign bus.sp_din        = sp_din_q;
  assign bus.sp_ld_en      = sp_ld_en_q;
  assign bus.sp_inc_dec_en = sp_inc_dec_en_q;
  assign bus.sp_inc_decn   = sp_inc_decn_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wr        = mem_wr_q;
  assign bus.mem_rd        = mem_rd_q;
  assign bus.pop_data      = pop_data_q;
  assign bus.pop_valid     = pop_valid_q;
  assign bus.depth         = depth_q;
  assign bus.err_ovf       = err_ovf_q;
  assign bus.err_unf       = err_unf_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed bench for stack_ctrl with an SP register, a memory responder and a transaction-level stack model.
module tb_stack_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  stack_ctrl_if #(.DEPTH_W(8)) bus();
  stack_ctrl #(.STACK_TOP(16'h0100), .MAX_DEPTH(64), .DEPTH_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  logic [15:0] mem [logic [15:0]];
  int kind = 0;
  logic [15:0] p_addr = '0, p_data = '0, msp = '0;
  int mdepth = 0;
  logic movf = 1'b0, munf = 1'b0;
  logic [15:0] stk [$];
  logic [15:0] popped [$];
  int act_dec = 0, exp_dec = 0, wr_cycles = 0;
  logic [15:0] last_wa = '0, last_wd = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.sp <= '0;
    else if (!bus.sp_ld_en) bus.sp <= bus.sp_din;
    else if (!bus.sp_inc_dec_en) bus.sp <= bus.sp_inc_decn ? bus.sp + 16'd2 : bus.sp - 16'd2;
  end
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_wr || bus.mem_rd) begin
        if (wcnt >= ack_delay) begin
          bus.mem_ack = 1'b1;
          wcnt = 0;
          if (bus.mem_rd) bus.mem_rdata = mem[bus.mem_addr];
          else mem[bus.mem_addr] = bus.mem_wdata;
        end else wcnt++;
      end else wcnt = 0;
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_ctl"}, {bus.cmd_ready, bus.sp_ld_en, bus.sp_inc_dec_en, bus.sp_inc_decn, bus.mem_wr, bus.mem_rd,
                       bus.pop_valid, bus.err_ovf, bus.err_unf}, 9'b1111_00000);
    chk({nm, "_data"}, {bus.sp_din, bus.mem_addr, bus.mem_wdata, bus.pop_data}, 64'h0);
    chk({nm, "_depth"}, bus.depth, 0);
  endtask
  task automatic send(input logic [1:0] op, input logic [15:0] d);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!bus.cmd_ready) chk("ready_timeout", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_data = d;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask
  task automatic do_cmd(input logic [1:0] op, input logic [15:0] d, output int cyc);
    send(op, d);
    cyc = 1;
    while (!bus.cmd_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (!bus.cmd_ready) chk("done_timeout", bus.cmd_ready, 1);
  endtask
  initial begin
    int cyc, d0, w0, n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_data = '0;
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          kind = 0; msp = '0; mdepth = 0; movf = 1'b0; munf = 1'b0;
          stk.delete();
        end else begin
          if (!bus.sp_inc_dec_en && !bus.sp_inc_decn) act_dec++;
          chk("strobe_excl", bus.sp_ld_en | bus.sp_inc_dec_en, 1);
          if (kind != 0) chk("busy_ready", bus.cmd_ready, 0);
          if (bus.mem_wr) begin
            wr_cycles++;
            chk("wr_kind", kind, 1);
            chk("wr_addr", bus.mem_addr, p_addr);
            chk("wr_data", bus.mem_wdata, p_data);
          end
          if (bus.mem_rd) begin
            chk("rd_kind", kind, 2);
            chk("rd_addr", bus.mem_addr, p_addr);
          end
          if (bus.pop_valid) begin
            chk("pop_kind", kind, 2);
            chk("pop_data", bus.pop_data, p_data);
            popped.push_back(bus.pop_data);
            kind = 0;
          end
          if (bus.mem_wr && bus.mem_ack) begin
            last_wa = bus.mem_addr;
            last_wd = bus.mem_wdata;
            kind = 0;
          end
          if (bus.cmd_ready) begin
            chk("idle_depth", bus.depth, mdepth);
            chk("idle_flags", {bus.err_ovf, bus.err_unf}, {movf, munf});
            chk("idle_sp", bus.sp, msp);
            chk("idle_dec_count", act_dec, exp_dec);
            chk("idle_quiet", {bus.mem_wr, bus.mem_rd, bus.sp_ld_en, bus.sp_inc_dec_en}, 4'b0011);
          end
          if (bus.cmd_valid && bus.cmd_ready) begin
            case (bus.cmd_op)
              2'b00: if (mdepth == 64) movf = 1'b1;
                     else begin
                       kind = 1; msp = msp - 16'd2; p_addr = msp; p_data = bus.cmd_data;
                       stk.push_front(bus.cmd_data); mdepth++; exp_dec++;
                     end
              2'b01: if (mdepth == 0) munf = 1'b1;
                     else begin
                       kind = 2; p_addr = msp; p_data = stk.pop_front(); msp = msp + 16'd2; mdepth--;
                     end
              default: begin
                msp = bus.cmd_op[0] ? 16'h0100 : bus.cmd_data;
                mdepth = 0; movf = 1'b0; munf = 1'b0;
                stk.delete();
              end
            endcase
          end
        end
      end
    join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_reset("reset");
    do_cmd(2'b11, 16'h0, cyc);
    chk("init_cycles", cyc, 2);
    do_cmd(2'b00, 16'hA5A5, cyc);
    chk("push_cycles", cyc, 3);
    chk("push_addr", last_wa, 16'h00FE);
    chk("push_data", last_wd, 16'hA5A5);
    chk("push_depth", bus.depth, 1);
    chk("push_dec_count", act_dec, 1);
    do_cmd(2'b11, 16'h0, cyc);
    do_cmd(2'b00, 16'h1111, cyc);
    do_cmd(2'b00, 16'h2222, cyc);
    do_cmd(2'b01, 16'h0, cyc);
    chk("pop_cycles", cyc, 3);
    do_cmd(2'b01, 16'h0, cyc);
    chk("pop_count", popped.size(), 2);
    if (popped.size() == 2) begin
      chk("pop_first", popped[0], 16'h2222);
      chk("pop_second", popped[1], 16'h1111);
    end
    chk("pop_sp", bus.sp, 16'h0100);
    chk("pop_depth", bus.depth, 0);
    do_cmd(2'b01, 16'h0, cyc);
    chk("unf_cycles", cyc, 1);
    @(posedge clk); #1;
    chk("unf_flag", bus.err_unf, 1);
    d0 = act_dec;
    for (int i = 0; i < 65; i++) do_cmd(2'b00, 16'(16'hC000 + i), cyc);
    chk("ovf_cycles", cyc, 1);
    @(posedge clk); #1;
    chk("ovf_flag", bus.err_ovf, 1);
    chk("ovf_depth", bus.depth, 64);
    chk("ovf_dec_count", act_dec - d0, 64);
    do_cmd(2'b10, 16'h2000, cyc);
    chk("load_cycles", cyc, 2);
    chk("load_flags", {bus.err_ovf, bus.err_unf}, 2'b00);
    chk("load_depth", bus.depth, 0);
    chk("load_sp", bus.sp, 16'h2000);
    ack_delay = 3;
    w0 = wr_cycles;
    do_cmd(2'b00, 16'h3C3C, cyc);
    chk("wait_cycles", cyc, 6);
    chk("wait_wr_len", wr_cycles - w0, 4);
    chk("wait_addr", last_wa, 16'h1FFE);
    chk("wait_data", last_wd, 16'h3C3C);
    ack_delay = 1000;
    send(2'b00, 16'h7777);
    n = 0;
    while (!bus.mem_wr && n < 20) begin @(posedge clk); #1; n++; end
    chk("rst_wr_seen", bus.mem_wr, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_wr_drop", bus.mem_wr, 0);
    chk_reset("async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    ack_delay = 0;
    do_cmd(2'b11, 16'h0, cyc);
    chk("post_rst_init", cyc, 2);
    do_cmd(2'b00, 16'h5A5A, cyc);
    chk("post_rst_push", cyc, 3);
    chk("post_rst_addr", last_wa, 16'h00FE);
    chk("post_rst_depth", bus.depth, 1);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
